// File: rtl/bsg_print_stat_pkg.sv
// ------------------------------------------------------------------
// bsg_print_stat_pkg: shared kind encoding and record layout
// Revision: 1.0
// ------------------------------------------------------------------
`default_nettype none

package bsg_print_stat_pkg;

  localparam int c_kind_width           = 2;
  localparam int c_default_tag_id_width = 4;
  localparam int c_default_ctr_width    = 32;

  typedef enum logic [c_kind_width-1:0] {
    e_stat_stat     = 2'b00,
    e_stat_start    = 2'b01,
    e_stat_end      = 2'b10,
    e_stat_reserved = 2'b11
  } print_stat_kind_e;

  typedef struct packed {
    logic [c_default_tag_id_width-1:0] tag_id;
    logic [c_default_ctr_width-1:0]    interval;
  } print_stat_rec_s;

  // The kind field always sits in the top bits of the tag word.
  function automatic print_stat_kind_e decode_kind(input logic [c_kind_width-1:0] bits);
    return print_stat_kind_e'(bits);
  endfunction

endpackage

`default_nettype wire

// File: rtl/bsg_print_stat_interval_tracker_fifo.sv
// ------------------------------------------------------------------
// bsg_print_stat_interval_tracker_fifo: small 1r1w record FIFO
// Revision: 1.0
// ------------------------------------------------------------------
`default_nettype none

module bsg_print_stat_interval_tracker_fifo #(
  parameter int width_p = 36,
  parameter int els_p   = 4
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  input  logic               yumi_i,
  output logic               full_o,
  output logic               v_o,
  output logic [width_p-1:0] data_o
);

  localparam int c_ptr_width = $clog2(els_p);
  localparam int c_cnt_width = $clog2(els_p + 1);

  logic [width_p-1:0]     mem [els_p];
  logic [c_ptr_width-1:0] rd_ptr;
  logic [c_ptr_width-1:0] wr_ptr;
  logic [c_cnt_width-1:0] count;

  assign v_o    = (count != '0);
  assign full_o = (count == c_cnt_width'(els_p));
  assign data_o = mem[rd_ptr];

  // Caller only writes when a slot is free or is being freed this cycle;
  // a write into the slot being read is safe because the read is combinational.
  always_ff @(posedge clk_i) begin
    if (v_i) begin
      mem[wr_ptr] <= data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (v_i) begin
        wr_ptr <= wr_ptr + c_ptr_width'(1);
      end
      if (yumi_i) begin
        rd_ptr <= rd_ptr + c_ptr_width'(1);
      end
      case ({v_i, yumi_i})
        2'b10:   count <= count + c_cnt_width'(1);
        2'b01:   count <= count - c_cnt_width'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/bsg_print_stat_interval_tracker.sv
// ------------------------------------------------------------------
// bsg_print_stat_interval_tracker: pairs START/END tags, logs intervals
// Revision: 1.0
// ------------------------------------------------------------------
`default_nettype none

module bsg_print_stat_interval_tracker
  import bsg_print_stat_pkg::*;
#(
  parameter int data_width_p    = 32,
  parameter int ctr_width_p     = 32,
  parameter int tag_id_width_p  = 4,
  parameter int fifo_els_p      = 4,
  parameter int err_ctr_width_p = 16
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       print_stat_v_i,
  input  logic [data_width_p-1:0]    print_stat_tag_i,
  input  logic [ctr_width_p-1:0]     global_ctr_i,
  output logic                       rec_v_o,
  output logic [tag_id_width_p-1:0]  rec_tag_id_o,
  output logic [ctr_width_p-1:0]     rec_interval_o,
  input  logic                       rec_yumi_i,
  input  logic [tag_id_width_p-1:0]  query_tag_id_i,
  output logic [ctr_width_p-1:0]     query_total_o,
  output logic [ctr_width_p-1:0]     query_count_o,
  output logic [err_ctr_width_p-1:0] err_restart_o,
  output logic [err_ctr_width_p-1:0] err_orphan_end_o,
  output logic [err_ctr_width_p-1:0] err_drop_o
);

  localparam int c_num_tags  = 1 << tag_id_width_p;
  localparam int c_rec_width = tag_id_width_p + ctr_width_p;

  print_stat_kind_e          kind;
  logic [tag_id_width_p-1:0] id;
  logic                      is_start, is_end, end_ok, orphan, restart;
  logic                      fifo_full, enq, drop;
  logic [ctr_width_p-1:0]    interval;
  logic [c_rec_width-1:0]    fifo_data;
  logic                      unused_tag_bits;

  logic [c_num_tags-1:0]     tag_open;
  logic [ctr_width_p-1:0]    start_ts [c_num_tags];
  logic [ctr_width_p-1:0]    total    [c_num_tags];
  logic [ctr_width_p-1:0]    count    [c_num_tags];

  assign kind     = decode_kind(print_stat_tag_i[data_width_p-1 -: c_kind_width]);
  assign id       = print_stat_tag_i[tag_id_width_p-1:0];
  assign unused_tag_bits = ^print_stat_tag_i[data_width_p-c_kind_width-1:tag_id_width_p];

  assign is_start = print_stat_v_i && (kind == e_stat_start);
  assign is_end   = print_stat_v_i && (kind == e_stat_end);
  assign end_ok   = is_end && tag_open[id];
  assign orphan   = is_end && !tag_open[id];
  assign restart  = is_start && tag_open[id];
  assign interval = global_ctr_i - start_ts[id];

  // A dequeue in the same cycle frees a slot, so a full FIFO still accepts.
  assign enq      = end_ok && (!fifo_full || rec_yumi_i);
  assign drop     = end_ok && !enq;

  assign query_total_o = total[query_tag_id_i];
  assign query_count_o = count[query_tag_id_i];

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      tag_open         <= '0;
      err_restart_o    <= '0;
      err_orphan_end_o <= '0;
      err_drop_o       <= '0;
      for (int i = 0; i < c_num_tags; i++) begin
        start_ts[i] <= '0;
        total[i]    <= '0;
        count[i]    <= '0;
      end
    end else begin
      if (is_start) begin
        start_ts[id] <= global_ctr_i;
        tag_open[id] <= 1'b1;
      end
      if (end_ok) begin
        tag_open[id] <= 1'b0;
        total[id]    <= total[id] + interval;
        count[id]    <= count[id] + ctr_width_p'(1);
      end
      if (restart && (err_restart_o != '1)) begin
        err_restart_o <= err_restart_o + err_ctr_width_p'(1);
      end
      if (orphan && (err_orphan_end_o != '1)) begin
        err_orphan_end_o <= err_orphan_end_o + err_ctr_width_p'(1);
      end
      if (drop && (err_drop_o != '1)) begin
        err_drop_o <= err_drop_o + err_ctr_width_p'(1);
      end
    end
  end

  bsg_print_stat_interval_tracker_fifo #(
    .width_p (c_rec_width),
    .els_p   (fifo_els_p)
  ) rec_fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .v_i       (enq),
    .data_i    ({id, interval}),
    .yumi_i    (rec_yumi_i),
    .full_o    (fifo_full),
    .v_o       (rec_v_o),
    .data_o    (fifo_data)
  );

  assign rec_tag_id_o   = fifo_data[c_rec_width-1 -: tag_id_width_p];
  assign rec_interval_o = fifo_data[ctr_width_p-1:0];

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (reset_n_i) begin
      assert (!(rec_yumi_i && !rec_v_o))
        else $error("rec_yumi_i asserted while rec_v_o is low");
      assert (!(print_stat_v_i && $isunknown(print_stat_tag_i)))
        else $error("unknown print_stat_tag_i while print_stat_v_i is high");
    end
  end
`endif

endmodule

`default_nettype wire
